sb_tx_seq_mc: RTL and testbench

- Parametrised successor to the sideband TX control FSM.
- Sequences the sideband transmit path: start-pattern generation, header/data encode, framing and an inter-message gap.
- Adds multi-channel round-robin message arbitration, a programmable end-of-message gap, and a sticky watchdog timeout on stalled encode/framing.
- Sits between the LTSM/RDI message sources and the SB header/data encoders, framer and pattern generator.

---
 rtl/sb_tx_seq_mc.sv | 225 ++++++++++++++++++++++
 tb/tb_sb_tx_seq_mc.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_tx_seq_mc.sv
`default_nettype none
// ============================================================================
//  Module   : sb_tx_seq_mc
//  Desc     : Sideband TX sequencer. Drives start-pattern generation, header
//             and data encode, framing and a programmable inter-message gap.
//             Arbitrates NUM_CH message requesters round-robin and aborts a
//             stalled encode/framing phase with a sticky watchdog error.
//  Revision : 1.0 - initial release
// ============================================================================
module sb_tx_seq_mc #(
  parameter int NUM_CH         = 4,
  parameter int GAP_CYCLES     = 6,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start_pattern_req,
  input  logic              i_start_pattern_done,
  input  logic [NUM_CH-1:0] i_msg_req,
  input  logic [NUM_CH-1:0] i_msg_has_data,
  input  logic              i_encode_done,
  input  logic              i_packet_valid,
  input  logic              i_err_clr,
  output logic              o_pattern_enable,
  output logic              o_pattern_done,
  output logic              o_pattern_abort,
  output logic [NUM_CH-1:0] o_msg_gnt,
  output logic [CH_W-1:0]   o_sel_ch,
  output logic              o_header_encoder_enable,
  output logic              o_data_encoder_enable,
  output logic              o_frame_enable,
  output logic              o_busy,
  output logic              o_timeout_err,
  output logic [2:0]        o_state
);

  // Counter widths cover the full legal parameter ranges (gap 1..15, timeout 2..1023).
  localparam int c_GAP_W = 4;
  localparam int c_WD_W  = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PATTERN = 3'd1,
    ST_ENCODE  = 3'd2,
    ST_FRAMING = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CH_W-1:0]     r_ptr;
  logic [CH_W-1:0]     w_ptr_nxt;
  logic [CH_W-1:0]     r_sel_ch;
  logic [CH_W-1:0]     w_sel_nxt;
  logic [c_GAP_W-1:0]  r_gap_cnt;
  logic [c_GAP_W-1:0]  w_gap_nxt;
  logic [c_WD_W-1:0]   r_wd_cnt;
  logic [c_WD_W-1:0]   w_wd_nxt;
  logic [NUM_CH-1:0]   r_msg_gnt;
  logic [NUM_CH-1:0]   w_gnt_nxt;
  logic                r_hdr_en;
  logic                w_hdr_nxt;
  logic                r_data_en;
  logic                w_data_nxt;
  logic                r_frame_en;
  logic                w_frame_nxt;
  logic                r_pat_done;
  logic                w_pat_done_nxt;
  logic                r_pat_abort;
  logic                w_pat_abort_nxt;
  logic                r_timeout_err;
  logic                w_to_set;
  logic                w_wd_expired;

  logic                w_win_found;
  logic [CH_W-1:0]     w_win;
  logic [CH_W-1:0]     w_scan_idx;

  // Round-robin winner: first pending channel scanning cyclically from r_ptr+1.
  always_comb begin
    w_win_found = 1'b0;
    w_win       = r_ptr;
    w_scan_idx  = r_ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      w_scan_idx = (w_scan_idx == CH_W'(NUM_CH - 1)) ? '0 : w_scan_idx + CH_W'(1);
      if (!w_win_found && i_msg_req[w_scan_idx]) begin
        w_win_found = 1'b1;
        w_win       = w_scan_idx;
      end
    end
  end

  // Watchdog budget is spent once the counter reaches TIMEOUT_CYCLES-1.
  assign w_wd_expired = (r_wd_cnt >= c_WD_W'(TIMEOUT_CYCLES - 1));

  // Next-state and next-pulse decode; pulses are registered below.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_sel_nxt       = r_sel_ch;
    w_gap_nxt       = r_gap_cnt;
    w_wd_nxt        = r_wd_cnt;
    w_gnt_nxt       = '0;
    w_hdr_nxt       = 1'b0;
    w_data_nxt      = 1'b0;
    w_frame_nxt     = 1'b0;
    w_pat_done_nxt  = 1'b0;
    w_pat_abort_nxt = 1'b0;
    w_to_set        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start_pattern_req) begin
          w_state_nxt = ST_PATTERN;
        end else if (w_win_found) begin
          w_state_nxt       = ST_ENCODE;
          w_ptr_nxt         = w_win;
          w_sel_nxt         = w_win;
          w_gnt_nxt[w_win]  = 1'b1;
          w_hdr_nxt         = 1'b1;
          w_data_nxt        = i_msg_has_data[w_win];
          w_wd_nxt          = '0;
        end
      end
      ST_PATTERN: begin
        // Normal completion outranks an abort arriving in the same cycle.
        if (i_start_pattern_done) begin
          w_state_nxt    = ST_IDLE;
          w_pat_done_nxt = 1'b1;
        end else if (|i_msg_req) begin
          w_state_nxt     = ST_IDLE;
          w_pat_abort_nxt = 1'b1;
        end
      end
      ST_ENCODE: begin
        if (i_encode_done) begin
          w_state_nxt = ST_FRAMING;
          w_frame_nxt = 1'b1;
          w_wd_nxt    = r_wd_cnt + c_WD_W'(1);
        end else if (w_wd_expired) begin
          w_state_nxt = ST_IDLE;
          w_to_set    = 1'b1;
        end else begin
          w_wd_nxt = r_wd_cnt + c_WD_W'(1);
        end
      end
      ST_FRAMING: begin
        if (i_packet_valid) begin
          w_state_nxt = ST_GAP;
          w_gap_nxt   = '0;
        end else if (w_wd_expired) begin
          w_state_nxt = ST_IDLE;
          w_to_set    = 1'b1;
        end else begin
          w_wd_nxt = r_wd_cnt + c_WD_W'(1);
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == c_GAP_W'(GAP_CYCLES - 1)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_nxt = r_gap_cnt + c_GAP_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, arbitration pointer, counters and registered pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= CH_W'(NUM_CH - 1);
      r_sel_ch    <= '0;
      r_gap_cnt   <= '0;
      r_wd_cnt    <= '0;
      r_msg_gnt   <= '0;
      r_hdr_en    <= 1'b0;
      r_data_en   <= 1'b0;
      r_frame_en  <= 1'b0;
      r_pat_done  <= 1'b0;
      r_pat_abort <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_sel_ch    <= w_sel_nxt;
      r_gap_cnt   <= w_gap_nxt;
      r_wd_cnt    <= w_wd_nxt;
      r_msg_gnt   <= w_gnt_nxt;
      r_hdr_en    <= w_hdr_nxt;
      r_data_en   <= w_data_nxt;
      r_frame_en  <= w_frame_nxt;
      r_pat_done  <= w_pat_done_nxt;
      r_pat_abort <= w_pat_abort_nxt;
    end
  end

  // Sticky watchdog error; a new timeout beats a simultaneous clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_timeout_err <= 1'b0;
    end else if (w_to_set) begin
      r_timeout_err <= 1'b1;
    end else if (i_err_clr) begin
      r_timeout_err <= 1'b0;
    end
  end

  assign o_pattern_enable        = (r_state == ST_PATTERN);
  assign o_busy                  = (r_state == ST_ENCODE) || (r_state == ST_FRAMING) ||
                                   (r_state == ST_GAP);
  assign o_state                 = r_state;
  assign o_pattern_done          = r_pat_done;
  assign o_pattern_abort         = r_pat_abort;
  assign o_msg_gnt               = r_msg_gnt;
  assign o_sel_ch                = r_sel_ch;
  assign o_header_encoder_enable = r_hdr_en;
  assign o_data_encoder_enable   = r_data_en;
  assign o_frame_enable          = r_frame_en;
  assign o_timeout_err           = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_sb_tx_seq_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sb_tx_seq_mc
//  Desc     : Directed self-checking bench for sb_tx_seq_mc with a grant
//             scoreboard (expected grants queued when requests are driven).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sb_tx_seq_mc;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start_pattern_req = 1'b0;
  logic       i_start_pattern_done = 1'b0;
  logic [3:0] i_msg_req = '0;
  logic [3:0] i_msg_has_data = '0;
  logic       i_encode_done = 1'b0;
  logic       i_packet_valid = 1'b0;
  logic       i_err_clr = 1'b0;
  logic       o_pattern_enable;
  logic       o_pattern_done;
  logic       o_pattern_abort;
  logic [3:0] o_msg_gnt;
  logic [1:0] o_sel_ch;
  logic       o_header_encoder_enable;
  logic       o_data_encoder_enable;
  logic       o_frame_enable;
  logic       o_busy;
  logic       o_timeout_err;
  logic [2:0] o_state;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       data;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   nb;
  int   n;

  sb_tx_seq_mc #(
    .NUM_CH(4),
    .GAP_CYCLES(6),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_start_pattern_req(i_start_pattern_req),
    .i_start_pattern_done(i_start_pattern_done),
    .i_msg_req(i_msg_req),
    .i_msg_has_data(i_msg_has_data),
    .i_encode_done(i_encode_done),
    .i_packet_valid(i_packet_valid),
    .i_err_clr(i_err_clr),
    .o_pattern_enable(o_pattern_enable),
    .o_pattern_done(o_pattern_done),
    .o_pattern_abort(o_pattern_abort),
    .o_msg_gnt(o_msg_gnt),
    .o_sel_ch(o_sel_ch),
    .o_header_encoder_enable(o_header_encoder_enable),
    .o_data_encoder_enable(o_data_encoder_enable),
    .o_frame_enable(o_frame_enable),
    .o_busy(o_busy),
    .o_timeout_err(o_timeout_err),
    .o_state(o_state)
  );

  // Free-running clock; DUT captures on posedge, bench acts on negedge.
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic push_exp(input logic [3:0] g, input logic [1:0] s, input logic d);
    exp_t e;
    e.gnt  = g;
    e.sel  = s;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 32'({o_pattern_enable, o_pattern_done, o_pattern_abort, o_msg_gnt, o_sel_ch,
                  o_header_encoder_enable, o_data_encoder_enable, o_frame_enable,
                  o_busy, o_timeout_err, o_state}), 32'd0);
  endtask

  // Wait (bounded) for a grant pulse and compare it with the scoreboard head.
  task automatic wait_grant(input string tag);
    int   k;
    exp_t e;
    k = 0;
    do begin
      step();
      k++;
    end while (o_msg_gnt == 4'd0 && k < 20);
    chk({tag, "_sb_depth_nonzero"}, 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_gnt"}, 32'(o_msg_gnt), 32'(e.gnt));
      chk({tag, "_sel"}, 32'(o_sel_ch), 32'(e.sel));
      chk({tag, "_hdr_en"}, 32'(o_header_encoder_enable), 32'd1);
      chk({tag, "_data_en"}, 32'(o_data_encoder_enable), 32'(e.data));
      chk({tag, "_busy"}, 32'(o_busy), 32'd1);
      chk({tag, "_state_enc"}, 32'(o_state), 32'd2);
    end
  endtask

  // From a negedge in ENCODE: complete encode and framing at once, count busy cycles.
  task automatic finish_msg(input string tag, output int nbusy);
    int guard;
    i_encode_done = 1'b1;
    nbusy = 1;
    step();
    nbusy++;
    chk({tag, "_frame_en"}, 32'(o_frame_enable), 32'd1);
    chk({tag, "_state_frm"}, 32'(o_state), 32'd3);
    chk({tag, "_hdr_dropped"}, 32'(o_header_encoder_enable), 32'd0);
    i_encode_done  = 1'b0;
    i_packet_valid = 1'b1;
    step();
    i_packet_valid = 1'b0;
    guard = 0;
    while (o_busy && guard < 40) begin
      nbusy++;
      guard++;
      step();
    end
    chk({tag, "_state_idle"}, 32'(o_state), 32'd0);
  endtask

  initial begin
    // Reset values
    step();
    step();
    chk_all_zero("reset_outs");
    i_rst = 1'b0;

    // Single message with data, quickest turnaround
    i_msg_req      = 4'b0001;
    i_msg_has_data = 4'b0001;
    push_exp(4'b0001, 2'd0, 1'b1);
    wait_grant("t1");
    i_msg_req = 4'b0000;
    finish_msg("t1", nb);
    chk("t1_busy_cycles", 32'(nb), 32'd8);

    // Fresh reset, then four held requests rotate through all channels
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    i_msg_has_data = 4'b0101;
    i_msg_req      = 4'b1111;
    push_exp(4'b0001, 2'd0, 1'b1);
    push_exp(4'b0010, 2'd1, 1'b0);
    push_exp(4'b0100, 2'd2, 1'b1);
    push_exp(4'b1000, 2'd3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      wait_grant($sformatf("t2_m%0d", k));
      finish_msg($sformatf("t2_m%0d", k), nb);
      chk($sformatf("t2_m%0d_busy_cycles", k), 32'(nb), 32'd8);
    end
    i_msg_req = 4'b0000;

    // Pattern request beats message; pending message then aborts the pattern
    i_start_pattern_req = 1'b1;
    i_msg_req           = 4'b0100;
    step();
    chk("t3_state_pat", 32'(o_state), 32'd1);
    chk("t3_pat_en", 32'(o_pattern_enable), 32'd1);
    chk("t3_no_gnt", 32'(o_msg_gnt), 32'd0);
    i_start_pattern_req = 1'b0;
    step();
    chk("t3_abort", 32'(o_pattern_abort), 32'd1);
    chk("t3_no_done", 32'(o_pattern_done), 32'd0);
    chk("t3_state_idle", 32'(o_state), 32'd0);
    chk("t3_pat_en_off", 32'(o_pattern_enable), 32'd0);
    push_exp(4'b0100, 2'd2, 1'b1);
    wait_grant("t3");
    i_msg_req = 4'b0000;
    finish_msg("t3", nb);

    // Done and message together: done wins, no abort
    i_start_pattern_req = 1'b1;
    step();
    chk("t3b_state_pat", 32'(o_state), 32'd1);
    i_start_pattern_req  = 1'b0;
    i_start_pattern_done = 1'b1;
    i_msg_req            = 4'b0100;
    step();
    chk("t3b_done", 32'(o_pattern_done), 32'd1);
    chk("t3b_no_abort", 32'(o_pattern_abort), 32'd0);
    chk("t3b_state_idle", 32'(o_state), 32'd0);
    i_start_pattern_done = 1'b0;
    i_msg_req            = 4'b0000;
    step();
    chk("t3b_done_one_cycle", 32'(o_pattern_done), 32'd0);
    chk("t3b_stay_idle", 32'(o_state), 32'd0);

    // Encode stall: watchdog fires after 64 ENCODE cycles
    i_msg_req = 4'b0001;
    push_exp(4'b0001, 2'd0, 1'b1);
    wait_grant("t5");
    i_msg_req = 4'b0000;
    n = 0;
    while (o_state == 3'd2 && n < 200) begin
      n++;
      step();
    end
    chk("t5_encode_cycles", 32'(n), 32'd64);
    chk("t5_state_idle", 32'(o_state), 32'd0);
    chk("t5_err_set", 32'(o_timeout_err), 32'd1);
    chk("t5_busy_off", 32'(o_busy), 32'd0);
    step();
    chk("t5_err_sticky", 32'(o_timeout_err), 32'd1);
    i_err_clr = 1'b1;
    step();
    i_err_clr = 1'b0;
    chk("t5_err_cleared", 32'(o_timeout_err), 32'd0);

    // encode_done on the last allowed cycle wins over the watchdog
    i_msg_req = 4'b0001;
    push_exp(4'b0001, 2'd0, 1'b1);
    wait_grant("t5b");
    i_msg_req = 4'b0000;
    repeat (63) step();
    chk("t5b_still_encode", 32'(o_state), 32'd2);
    finish_msg("t5b", nb);
    chk("t5b_no_err", 32'(o_timeout_err), 32'd0);

    // Asynchronous reset during FRAMING, then pointer restarts from ch0
    i_msg_req = 4'b0010;
    push_exp(4'b0010, 2'd1, 1'b0);
    wait_grant("t6");
    i_msg_req     = 4'b0000;
    i_encode_done = 1'b1;
    step();
    i_encode_done = 1'b0;
    chk("t6_state_frm", 32'(o_state), 32'd3);
    #2 i_rst = 1'b1;
    #1 chk_all_zero("t6_async_reset");
    step();
    i_rst     = 1'b0;
    i_msg_req = 4'b1010;
    push_exp(4'b0010, 2'd1, 1'b0);
    wait_grant("t6_post");
    i_msg_req = 4'b0000;
    finish_msg("t6_post", nb);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
